// File: rtl/swap_pkg.sv
// Shared definitions for the swap checker.
// Holds the checker FSM state type and the default lock length and
// counter width used by swap_checker.
package swap_pkg;

   // Default number of consecutive good swaps needed before lock
   localparam int DEFAULT_LOCK_LEN = 4;

   // Default width of the good and error counters
   localparam int DEFAULT_CNT_W = 8;

   // Checker FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAMPLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_LOCKED = 3'd3,
      ST_FAIL   = 3'd4
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Counts inc_i pulses and sticks at the all-ones value instead of wrapping.
// A synchronous clear wins over increment.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears the count
//   inc_i  - increment request for this cycle
//   clr_i  - synchronous clear
//   cnt_o  - current count, W bits
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear first, then increment unless already at the ceiling
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/swap_checker.sv
// Swap checker.
// Watches the a/b outputs of an upstream swap stage and verifies that every
// cycle the pair exchanges its values (a takes the old b, b takes the old a).
// After LOCK_LEN consecutive good swaps the checker locks; a bad swap while
// locked is latched as a sticky error and parks the FSM in FAIL until clr_i.
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   en_i        - checker enable; dropping it returns the FSM to IDLE
//   clr_i       - synchronous clear of counters, sticky error and FSM
//   a_i, b_i    - upstream register-pair outputs
//   lock_o      - high while locked
//   err_o       - sticky error flag
//   good_cnt_o  - saturating count of good swaps
//   err_cnt_o   - saturating count of bad swaps
module swap_checker
   import swap_pkg::*;
#(
   parameter int LOCK_LEN = DEFAULT_LOCK_LEN,
   parameter int CNT_W    = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             a_i,
   input  logic             b_i,
   output logic             lock_o,
   output logic             err_o,
   output logic [CNT_W-1:0] good_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   // Run counter is just wide enough to hold LOCK_LEN
   localparam int RUN_W = $clog2(LOCK_LEN + 1);
   localparam logic [RUN_W-1:0] LOCK_VAL = RUN_W'(LOCK_LEN);

   state_e           state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             prev_a_q, prev_a_d;
   logic             prev_b_q, prev_b_d;
   logic             err_q, err_d;

   logic             good_swap;
   logic [RUN_W-1:0] run_inc;
   logic             good_inc;
   logic             err_inc;
   logic             cnt_clr;

   assign good_swap = (a_i == prev_b_q) && (b_i == prev_a_q);
   assign run_inc   = run_q + RUN_W'(1);

   // Next-state logic. Priority: clear, then FAIL hold, then enable drop,
   // then the normal sample/compare flow. The previous pair is refreshed in
   // every active state so each compare always looks one cycle back.
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      err_d    = err_q;
      prev_a_d = prev_a_q;
      prev_b_d = prev_b_q;
      good_inc = 1'b0;
      err_inc  = 1'b0;
      cnt_clr  = 1'b0;

      if ((state_q != ST_IDLE) && (state_q != ST_FAIL)) begin
         prev_a_d = a_i;
         prev_b_d = b_i;
      end

      if (clr_i) begin
         state_d = ST_IDLE;
         run_d   = '0;
         err_d   = 1'b0;
         cnt_clr = 1'b1;
      end else if (state_q == ST_FAIL) begin
         state_d = ST_FAIL;
      end else if (!en_i) begin
         state_d = ST_IDLE;
         run_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
               state_d = ST_CHECK;
            end
            ST_CHECK: begin
               if (good_swap) begin
                  good_inc = 1'b1;
                  run_d    = run_inc;
                  if (run_inc == LOCK_VAL) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  err_inc = 1'b1;
                  run_d   = '0;
               end
            end
            ST_LOCKED: begin
               if (good_swap) begin
                  good_inc = 1'b1;
               end else begin
                  err_inc = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_FAIL;
               end
            end
            default: begin
               state_d = ST_IDLE;
               run_d   = '0;
            end
         endcase
      end
   end

   // State, run length, previous pair and sticky error registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         run_q    <= '0;
         prev_a_q <= 1'b0;
         prev_b_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         prev_a_q <= prev_a_d;
         prev_b_q <= prev_b_d;
         err_q    <= err_d;
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_good_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (good_inc),
      .clr_i (cnt_clr),
      .cnt_o (good_cnt_o)
   );

   sat_counter #(
      .W(CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (err_inc),
      .clr_i (cnt_clr),
      .cnt_o (err_cnt_o)
   );

   assign lock_o = (state_q == ST_LOCKED);
   assign err_o  = err_q;

endmodule

// File: tb/tb_swap_checker.sv
// Testbench for swap_checker.
// Two instances share the same inputs: one with default parameters and one
// with LOCK_LEN=1, CNT_W=3 to exercise single-swap lock and saturation.
// A behavioural model tracks each instance and outputs are compared after
// every clock edge, alongside directed checks of specific scenarios.
module tb_swap_checker;

   logic       clk;
   logic       rst_n;
   logic       en_i;
   logic       clr_i;
   logic       a_i;
   logic       b_i;

   logic       lockA, errA;
   logic [7:0] goodCntA, errCntA;
   logic       lockB, errB;
   logic [2:0] goodCntB, errCntB;

   int         checks = 0;
   int         errors = 0;
   logic       lastA, lastB;

   // Behavioural view of one checker: phase flags plus plain integer counts
   typedef struct {
      bit active;
      bit havePrev;
      bit locked;
      bit failed;
      bit pa;
      bit pb;
      int run;
      int goodCnt;
      int errCnt;
      bit errFlag;
   } mdlT;

   mdlT mdl [2];
   int  lockLen [2] = '{4, 1};
   int  cntMax  [2] = '{255, 7};

   swap_checker dutA (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .lock_o     (lockA),
      .err_o      (errA),
      .good_cnt_o (goodCntA),
      .err_cnt_o  (errCntA)
   );

   swap_checker #(
      .LOCK_LEN (1),
      .CNT_W    (3)
   ) dutB (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .lock_o     (lockB),
      .err_o      (errB),
      .good_cnt_o (goodCntB),
      .err_cnt_o  (errCntB)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic mdlT modelReset();
      mdlT s;
      s.active = 0; s.havePrev = 0; s.locked = 0; s.failed = 0;
      s.pa = 0; s.pb = 0; s.run = 0; s.goodCnt = 0; s.errCnt = 0;
      s.errFlag = 0;
      return s;
   endfunction

   // One clock edge of the reference behaviour
   function automatic mdlT modelStep(input mdlT sIn, input int lockN,
                                     input int maxCnt, input bit rstN,
                                     input bit en, input bit clr,
                                     input bit a, input bit b);
      mdlT s;
      bit good;
      s = sIn;
      if (!rstN) return modelReset();
      if (clr) begin
         s.active = 0; s.havePrev = 0; s.locked = 0; s.failed = 0;
         s.run = 0; s.goodCnt = 0; s.errCnt = 0; s.errFlag = 0;
      end else if (s.failed) begin
         return s;
      end else if (!en) begin
         s.active = 0; s.havePrev = 0; s.locked = 0; s.run = 0;
      end else if (!s.active) begin
         s.active = 1;
         s.havePrev = 0;
      end else if (!s.havePrev) begin
         s.havePrev = 1;
         s.pa = a; s.pb = b;
      end else begin
         good = (a == s.pb) && (b == s.pa);
         s.pa = a; s.pb = b;
         if (good) begin
            if (s.goodCnt < maxCnt) s.goodCnt++;
            if (!s.locked) begin
               s.run++;
               if (s.run >= lockN) s.locked = 1;
            end
         end else begin
            if (s.errCnt < maxCnt) s.errCnt++;
            if (s.locked) begin
               s.locked = 0;
               s.failed = 1;
               s.errFlag = 1;
            end else begin
               s.run = 0;
            end
         end
      end
      return s;
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Compare both instances against the model
   task automatic checkOutput();
      checkValue("A.lock",    32'(lockA),    32'(mdl[0].locked));
      checkValue("A.err",     32'(errA),     32'(mdl[0].errFlag));
      checkValue("A.goodCnt", 32'(goodCntA), 32'(mdl[0].goodCnt));
      checkValue("A.errCnt",  32'(errCntA),  32'(mdl[0].errCnt));
      checkValue("B.lock",    32'(lockB),    32'(mdl[1].locked));
      checkValue("B.err",     32'(errB),     32'(mdl[1].errFlag));
      checkValue("B.goodCnt", 32'(goodCntB), 32'(mdl[1].goodCnt));
      checkValue("B.errCnt",  32'(errCntB),  32'(mdl[1].errCnt));
   endtask

   // Drive one cycle of inputs, advance the model on the edge, then compare
   task automatic applyStimulus(input bit en, input bit clr, input bit a,
                                input bit b);
      en_i  = en;
      clr_i = clr;
      a_i   = a;
      b_i   = b;
      lastA = a;
      lastB = b;
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         mdl[m] = modelStep(mdl[m], lockLen[m], cntMax[m], rst_n, en, clr,
                            a, b);
      end
      #1;
      checkOutput();
   endtask

   initial begin
      rst_n = 1'b0;
      en_i  = 1'b0;
      clr_i = 1'b0;
      a_i   = 1'b1;
      b_i   = 1'b0;
      lastA = 1'b1;
      lastB = 1'b0;
      mdl[0] = modelReset();
      mdl[1] = modelReset();

      // Reset state with the upstream reset pattern on the inputs
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      checkValue("reset.lock", 32'(lockA), 32'd0);
      rst_n = 1'b1;

      // Enable, sample the 1/0 pair, then five alternating good swaps
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 1);
      checkValue("lock.before4", 32'(lockA), 32'd0);
      applyStimulus(1, 0, 1, 0);
      checkValue("lock.after4", 32'(lockA), 32'd1);
      applyStimulus(1, 0, 0, 1);
      checkValue("lock.goodCnt5", 32'(goodCntA), 32'd5);
      checkValue("lock.errCnt0", 32'(errCntA), 32'd0);

      // Fault while locked, then toggle enable with counters frozen
      applyStimulus(1, 0, 1, 1);
      checkValue("fault.err", 32'(errA), 32'd1);
      checkValue("fault.errCnt", 32'(errCntA), 32'd1);
      checkValue("fault.lock", 32'(lockA), 32'd0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(1, 0, 0, 0);
      checkValue("fail.goodCnt", 32'(goodCntA), 32'd5);
      checkValue("fail.errCnt", 32'(errCntA), 32'd1);
      checkValue("fail.err", 32'(errA), 32'd1);

      // Clear together with enable while in FAIL
      applyStimulus(1, 1, 1, 0);
      checkValue("clr.lock", 32'(lockA), 32'd0);
      checkValue("clr.err", 32'(errA), 32'd0);
      checkValue("clr.goodCnt", 32'(goodCntA), 32'd0);
      checkValue("clr.errCnt", 32'(errCntA), 32'd0);

      // Two good swaps, one bad, then four good static-equal swaps
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 0);
      checkValue("prelock.errCnt", 32'(errCntA), 32'd1);
      checkValue("prelock.err", 32'(errA), 32'd0);
      repeat (3) applyStimulus(1, 0, 0, 0);
      checkValue("prelock.lock3", 32'(lockA), 32'd0);
      applyStimulus(1, 0, 0, 0);
      checkValue("prelock.lock4", 32'(lockA), 32'd1);
      checkValue("prelock.goodCnt", 32'(goodCntA), 32'd6);

      // Saturation on the narrow instance, which also locks after one swap
      applyStimulus(0, 1, 1, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 1);
      checkValue("len1.lock", 32'(lockB), 32'd1);
      for (int i = 1; i < 10; i++) begin
         applyStimulus(1, 0, lastB, lastA);
      end
      checkValue("sat.goodCntB", 32'(goodCntB), 32'd7);
      checkValue("sat.goodCntA", 32'(goodCntA), 32'd10);

      // Asynchronous reset in the middle of a cycle while locked
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkValue("arst.lockA", 32'(lockA), 32'd0);
      checkValue("arst.goodCntA", 32'(goodCntA), 32'd0);
      checkValue("arst.errCntA", 32'(errCntA), 32'd0);
      checkValue("arst.lockB", 32'(lockB), 32'd0);
      checkValue("arst.goodCntB", 32'(goodCntB), 32'd0);
      mdl[0] = modelReset();
      mdl[1] = modelReset();
      applyStimulus(1, 0, 1, 0);
      rst_n = 1'b1;

      // Randomized traffic biased toward good swaps
      for (int i = 0; i < 400; i++) begin
         bit en, clr, a, b;
         en  = ($urandom_range(0, 99) < 92);
         clr = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 99) < 80) begin
            a = lastB;
            b = lastA;
         end else begin
            a = 1'($urandom);
            b = 1'($urandom);
         end
         if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
         applyStimulus(en, clr, a, b);
         rst_n = 1'b1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
